// File: rtl/stats_reporter_pkg.sv
// Shared constants, frame types and the nibble-to-ASCII helper for the telemetry reporter.
package stats_reporter_pkg;

    localparam int         FRAME_LEN = 11;
    localparam logic [7:0] SOF       = 8'h53;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] hunger;
        logic [3:0] happiness;
        logic [3:0] health;
        logic [3:0] hygiene;
        logic [3:0] energy;
        logic [3:0] social;
        logic [6:0] status;
    } snapshot_t;

    // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        logic [7:0] wide;
        wide = {4'h0, nibble};
        if (nibble < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h37 + wide;
    endfunction

endpackage

// File: rtl/stats_reporter_uart_tx.sv
// 8N1 UART transmitter, LSB first, one start strobe per byte.
// The start bit is driven onto tx in the same cycle the strobe is accepted,
// so the line reacts without an extra register stage of latency.
module uart_tx #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    logic        ready_q, ready_d;
    logic        tx_q, tx_d;
    logic [8:0]  shift_q, shift_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic        accept;

    assign accept = start & ready_q;
    assign ready  = ready_q;
    assign tx     = tx_q & ~accept;

    // Bit timing: accept a byte, then walk start, 8 data bits and stop bit.
    always_comb begin
        ready_d   = ready_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        clk_cnt_d = clk_cnt_q;
        if (accept) begin
            ready_d   = 1'b0;
            tx_d      = 1'b0;
            shift_d   = {1'b1, data};
            bit_d     = 4'd0;
            clk_cnt_d = 16'd1;
        end else if (!ready_q) begin
            if (clk_cnt_q == CLKS_PER_BIT - 16'd1) begin
                clk_cnt_d = 16'd0;
                if (bit_q == 4'd9) begin
                    ready_d = 1'b1;
                    tx_d    = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 16'd1;
            end
        end
    end

    // Transmitter state registers; the line idles high out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b1;
            tx_q      <= 1'b1;
            shift_q   <= '1;
            bit_q     <= 4'd0;
            clk_cnt_q <= 16'd0;
        end else begin
            ready_q   <= ready_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            clk_cnt_q <= clk_cnt_d;
        end
    end

endmodule

// File: rtl/stats_reporter.sv
// Telemetry reporter: snapshots the pet stats and status, formats an
// 11-byte ASCII frame and streams it on a dedicated UART TX line.
module stats_reporter
    import stats_reporter_pkg::*;
#(
    parameter logic [23:0] PERIOD       = 24'd10_000_000,
    parameter logic [15:0] CLKS_PER_BIT = 16'd87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    input  logic [6:0] status,
    input  logic       enable,
    input  logic       request,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0]  LAST_IDX       = 4'(FRAME_LEN - 1);
    // The last byte is timed locally so that busy falls and frame_done fires
    // on the final stop-bit cycle, keeping busy high for exactly
    // 11 bytes plus 10 inter-byte gaps.
    localparam logic [19:0] LAST_BYTE_WAIT = 20'(10 * int'(CLKS_PER_BIT) - 3);

    state_e      state_q, state_d;
    logic [23:0] period_q, period_d;
    logic        pending_q, pending_d;
    snapshot_t   snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;
    logic [19:0] timer_q, timer_d;
    logic        period_wrap;
    logic        uart_start;
    logic        uart_ready;
    logic [7:0]  uart_data;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one pass through LOAD, then SEND/WAIT per byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pending_q) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (idx_q != LAST_IDX) begin
                    if (uart_ready) state_d = ST_SEND;
                end else if (timer_q == 20'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: period counter, coalescing trigger flag, snapshot, byte index.
    always_comb begin
        period_wrap = enable && (period_q == PERIOD - 24'd1);
        period_d    = period_q;
        pending_d   = pending_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        timer_d     = timer_q;

        if (enable) begin
            period_d = period_wrap ? 24'd0 : period_q + 24'd1;
        end

        if (state_q == ST_IDLE && pending_q) begin
            pending_d        = 1'b0;
            snap_d.hunger    = hunger;
            snap_d.happiness = happiness;
            snap_d.health    = health;
            snap_d.hygiene   = hygiene;
            snap_d.energy    = energy;
            snap_d.social    = social;
            snap_d.status    = status;
        end
        if (request || period_wrap) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_LOAD: idx_d = 4'd0;
            ST_SEND: timer_d = LAST_BYTE_WAIT;
            ST_WAIT: begin
                if (idx_q != LAST_IDX && uart_ready) idx_d = idx_q + 4'd1;
                if (timer_q != 20'd0) timer_d = timer_q - 20'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q  <= 24'd0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            idx_q     <= 4'd0;
            timer_q   <= 20'd0;
        end else begin
            period_q  <= period_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
        end
    end

    // Outputs: status flags, start strobe and the frame byte for the current index.
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        uart_start = 1'b0;
        case (state_q)
            ST_LOAD, ST_WAIT: busy = 1'b1;
            ST_SEND: begin
                busy       = 1'b1;
                uart_start = 1'b1;
            end
            ST_DONE: frame_done = 1'b1;
            default: ;
        endcase

        case (idx_q)
            4'd0:    uart_data = SOF;
            4'd1:    uart_data = hex_ascii(snap_q.hunger);
            4'd2:    uart_data = hex_ascii(snap_q.happiness);
            4'd3:    uart_data = hex_ascii(snap_q.health);
            4'd4:    uart_data = hex_ascii(snap_q.hygiene);
            4'd5:    uart_data = hex_ascii(snap_q.energy);
            4'd6:    uart_data = hex_ascii(snap_q.social);
            4'd7:    uart_data = hex_ascii({1'b0, snap_q.status[6:4]});
            4'd8:    uart_data = hex_ascii(snap_q.status[3:0]);
            4'd9:    uart_data = CR;
            default: uart_data = LF;
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .start(uart_start),
        .data (uart_data),
        .tx   (tx),
        .ready(uart_ready)
    );

endmodule

// File: tb/tb_stats_reporter.sv
// Directed self-checking bench for stats_reporter with PERIOD=1000, CLKS_PER_BIT=4.
module tb_stats_reporter;

    localparam int CPB      = 4;
    localparam int RX_BOUND = 1200;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic [6:0] status;
    logic       enable, request;
    logic       tx, busy, frame_done;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int done_count = 0;
    int done_cycle = 0;
    int busy_run = 0;
    int busy_len = 0;

    logic [7:0] rx [11];
    logic [7:0] exp_t1 [11] = '{8'h53, 8'h33, 8'h41, 8'h46, 8'h30, 8'h37, 8'h43, 8'h35, 8'h35, 8'h0D, 8'h0A};
    logic [7:0] exp_z  [11] = '{8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] exp_f  [11] = '{8'h53, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h30, 8'h30, 8'h0D, 8'h0A};

    stats_reporter #(
        .PERIOD      (24'd1000),
        .CLKS_PER_BIT(16'd4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hunger    (hunger),
        .happiness (happiness),
        .health    (health),
        .hygiene   (hygiene),
        .energy    (energy),
        .social    (social),
        .status    (status),
        .enable    (enable),
        .request   (request),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Free-running cycle count used as a time base for latency checks.
    always @(posedge clk) cycle <= cycle + 1;

    // Count frame_done cycles and measure each busy high stretch.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_count++;
            done_cycle = cycle;
        end
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] hu, input logic [3:0] ha, input logic [3:0] he,
                                 input logic [3:0] hy, input logic [3:0] en, input logic [3:0] so,
                                 input logic [6:0] st);
        hunger    = hu;
        happiness = ha;
        health    = he;
        hygiene   = hy;
        energy    = en;
        social    = so;
        status    = st;
    endtask

    task automatic pulseRequest(output int at);
        at      = cycle;
        request = 1'b1;
        @(negedge clk);
        request = 1'b0;
    endtask

    task automatic waitTxLow(input int bound, output bit found, output int at);
        found = 1'b0;
        at    = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                at    = cycle;
                return;
            end
        end
    endtask

    task automatic receiveByte(output logic [7:0] b, output bit ok, output int start_cycle);
        bit found;
        b  = 8'h00;
        ok = 1'b0;
        waitTxLow(RX_BOUND, found, start_cycle);
        if (!found) return;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        ok = (tx === 1'b1);
    endtask

    task automatic receiveFrame(output bit ok, output int first);
        logic [7:0] b;
        bit         bok;
        int         st;
        ok    = 1'b1;
        first = 0;
        for (int i = 0; i < 11; i++) begin
            receiveByte(b, bok, st);
            rx[i] = b;
            if (i == 0) first = st;
            if (!bok) ok = 1'b0;
        end
    endtask

    initial begin
        bit ok, ok2, found;
        int req_at, first, first2, d0, r, dummy;

        reset   = 1'b1;
        enable  = 1'b0;
        request = 1'b0;
        applyStimulus(4'h3, 4'hA, 4'hF, 4'h0, 4'h7, 4'hC, 7'h55);
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Basic request-driven frame.
        $display("[TB] request frame");
        d0 = done_count;
        pulseRequest(req_at);
        receiveFrame(ok, first);
        checkOutput("t1_rx_ok", ok, 1);
        for (int i = 0; i < 11; i++) checkOutput($sformatf("t1_byte%0d", i), rx[i], exp_t1[i]);
        checkOutput("t1_start_latency", first - req_at, 3);
        repeat (10) @(negedge clk);
        checkOutput("t1_done_count", done_count - d0, 1);
        checkOutput("t1_done_timing", done_cycle - first, 449);
        checkOutput("t1_busy_len", busy_len, 450);
        checkOutput("t1_idle_busy", busy, 0);

        // Inputs change right after capture; frame must not follow them.
        $display("[TB] snapshot");
        pulseRequest(req_at);
        @(negedge clk);
        applyStimulus(4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 7'h00);
        receiveFrame(ok, first);
        checkOutput("t2_rx_ok", ok, 1);
        for (int i = 0; i < 11; i++) checkOutput($sformatf("t2_byte%0d", i), rx[i], exp_t1[i]);
        repeat (10) @(negedge clk);

        // All-F stats.
        $display("[TB] all F stats");
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 7'h00);
        pulseRequest(req_at);
        receiveFrame(ok, first);
        checkOutput("tf_rx_ok", ok, 1);
        for (int i = 0; i < 11; i++) checkOutput($sformatf("tf_byte%0d", i), rx[i], exp_f[i]);
        repeat (10) @(negedge clk);

        // Several requests during a frame coalesce into one follow-up frame.
        $display("[TB] coalescing");
        applyStimulus(4'h3, 4'hA, 4'hF, 4'h0, 4'h7, 4'hC, 7'h55);
        d0 = done_count;
        pulseRequest(req_at);
        fork
            begin
                receiveFrame(ok, first);
                receiveFrame(ok2, first2);
            end
            begin
                repeat (40) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    pulseRequest(dummy);
                    repeat (19) @(negedge clk);
                end
            end
        join
        checkOutput("tc_rx1_ok", ok, 1);
        checkOutput("tc_rx2_ok", ok2, 1);
        for (int i = 0; i < 11; i++) checkOutput($sformatf("tc_byte%0d", i), rx[i], exp_t1[i]);
        checkOutput("tc_back_to_back", first2 - first, 452);
        waitTxLow(700, found, dummy);
        checkOutput("tc_no_third_frame", found, 0);
        checkOutput("tc_done_count", done_count - d0, 2);

        // Reset while a zero data bit of byte 5 is on the line.
        $display("[TB] reset mid-frame");
        d0 = done_count;
        pulseRequest(req_at);
        waitTxLow(RX_BOUND, found, first);
        checkOutput("tr_started", found, 1);
        repeat (100) @(negedge clk);
        pulseRequest(dummy);
        repeat (120) @(negedge clk);
        checkOutput("tr_pre_tx", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("tr_tx_high", tx, 1);
        checkOutput("tr_busy_low", busy, 0);
        checkOutput("tr_no_done_now", frame_done, 0);
        waitTxLow(600, found, dummy);
        checkOutput("tr_pending_cleared", found, 0);
        checkOutput("tr_no_done", done_count - d0, 0);
        pulseRequest(req_at);
        receiveFrame(ok, first);
        checkOutput("tr_rx_ok", ok, 1);
        for (int i = 0; i < 11; i++) checkOutput($sformatf("tr_byte%0d", i), rx[i], exp_t1[i]);
        repeat (10) @(negedge clk);

        // Automatic reports; r+1 is the first clock edge that sees reset released.
        $display("[TB] periodic");
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'h7F);
        enable = 1'b1;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        r     = cycle;
        receiveFrame(ok, first);
        checkOutput("tp_rx_ok", ok, 1);
        for (int i = 0; i < 11; i++) checkOutput($sformatf("tp_byte%0d", i), rx[i], exp_z[i]);
        checkOutput("tp_first", first - (r + 1), 1001);
        receiveFrame(ok, first);
        checkOutput("tp_second", first - (r + 1), 2001);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        enable = 1'b1;
        receiveFrame(ok, first);
        checkOutput("tp_third_held", first - (r + 1), 3051);
        enable = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
